// File: rtl/fauxfs_wfile_drain.sv
// fauxfs_wfile_drain: Wishbone master that bursts each 2 KB write-file sector into a
// valid/ready stream, then acks the sector and clears the pending flag.
module fauxfs_wfile_drain #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          BURST_LEN  = 8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        enable_i,
    input  logic        wfile_dat_int_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [31:0] m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [15:0] sector_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] BMASK = 10'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD, GAP, FLUSH, ACKWR, CLRWR, REARM, ERR} state_t;

    state_t        state;
    logic [9:0]    idx;
    logic [9:0]    idx_next;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, free_ok, last_beat;

    assign idx_next  = idx + 10'd1;
    assign last_beat = (idx & BMASK) == BMASK;
    assign push      = state == RD && wbm_cyc_o && wbm_ack_i && !wbm_err_i;
    assign m_valid_o = count != '0;
    assign pop       = m_valid_o && m_ready_i;
    assign m_data_o  = m_valid_o ? mem[rd_ptr][31:0] : 32'h0;
    assign m_last_o  = m_valid_o && mem[rd_ptr][32];
    assign free_ok   = count <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
    assign busy_o    = state != IDLE;
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_bte_o = 2'b00;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= {idx == 10'd511, wbm_dat_i};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state        <= IDLE;
            idx          <= '0;
            wbm_cyc_o    <= 1'b0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            wbm_sel_o    <= '0;
            wbm_we_o     <= 1'b0;
            wbm_cti_o    <= '0;
            sector_cnt_o <= '0;
            err_o        <= 1'b0;
        end else if (wbm_cyc_o && wbm_err_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_cti_o <= 3'b000;
            err_o     <= 1'b1;
            state     <= ERR;
        end else begin
            case (state)
                IDLE: if (enable_i && wfile_dat_int_i) begin
                    idx   <= '0;
                    state <= GAP;
                end
                GAP: if (free_ok) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= BASE_ADR + {20'h0, idx, 2'b00};
                    wbm_cti_o <= last_beat ? 3'b111 : 3'b010;
                    state     <= RD;
                end
                RD: if (wbm_ack_i) begin
                    idx       <= idx_next;
                    wbm_adr_o <= wbm_adr_o + 32'd4;
                    if (last_beat) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_cti_o <= 3'b000;
                        state     <= idx_next[9] ? FLUSH : GAP;
                    end else if ((idx_next & BMASK) == BMASK) begin
                        wbm_cti_o <= 3'b111;
                    end
                end
                FLUSH: if (!m_valid_o) state <= ACKWR;
                // Both writes idle one cycle with cyc low before raising it
                ACKWR: if (!wbm_cyc_o) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= BASE_ADR + 32'h1000;
                    wbm_dat_o <= {16'h0, sector_cnt_o + 16'd1};
                end else if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    state     <= CLRWR;
                end
                CLRWR: if (!wbm_cyc_o) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'h1;
                    wbm_adr_o <= BASE_ADR + 32'h1020;
                    wbm_dat_o <= 32'h1;
                end else if (wbm_ack_i) begin
                    wbm_cyc_o    <= 1'b0;
                    wbm_we_o     <= 1'b0;
                    sector_cnt_o <= sector_cnt_o + 16'd1;
                    state        <= REARM;
                end
                REARM: if (!wfile_dat_int_i) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fauxfs_wfile_drain.sv
// tb_fauxfs_wfile_drain: random-ready stream and model slave, checked against
// per-sector expected transaction and word lists.
module tb_fauxfs_wfile_drain;
    logic        clk = 0, rst_n = 0, enable = 0, wint = 0, ready = 0, err_arm = 0;
    int          ready_mode = 0;
    logic [31:0] adr, dat_o, dat_i, m_data;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, m_valid, m_last, busy, err_o;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [15:0] cnt;
    logic        ack_w = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic        first;
    } trans_t;

    trans_t      trans_q[$];
    logic [32:0] strm_q[$];
    int          occ = 0, max_occ = 0, start_viol = 0, proto_viol = 0;
    logic        beat_seen = 0, prev_cyc = 0;
    int          vectors = 0, miscompares = 0;

    fauxfs_wfile_drain dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(enable), .wfile_dat_int_i(wint),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
        .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(ready),
        .busy_o(busy), .err_o(err_o), .sector_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // Slave: reads ack every cycle, writes ack one cycle after stb
    assign dat_i = 32'hA500_0000 + {23'h0, adr[10:2]};
    assign err   = err_arm && cyc && stb && !we && adr == 32'h14C;
    assign ack   = we ? ack_w : (cyc && stb && !err);
    always @(posedge clk) ack_w <= cyc && stb && we && !ack_w;

    always @(negedge clk) ready = (ready_mode == 2) ? ($urandom_range(99) < 30) : (ready_mode == 1);

    always @(posedge clk) begin
        if (!rst_n) begin
            occ       <= 0;
            beat_seen <= 1'b0;
            prev_cyc  <= 1'b0;
        end else begin
            if (cyc && ack) trans_q.push_back({adr, we ? dat_o : dat_i, sel, we, cti, !beat_seen});
            if (m_valid && ready) strm_q.push_back({m_last, m_data});
            if (cyc && !prev_cyc && !we && occ > 8) start_viol <= start_viol + 1;
            if (cyc !== stb || bte !== 2'b00) proto_viol <= proto_viol + 1;
            if (occ > max_occ) max_occ <= occ;
            occ       <= occ + int'(cyc && ack && !we) - int'(m_valid && ready);
            beat_seen <= cyc && (beat_seen || ack);
            prev_cyc  <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic trans_t exp_trans(input int k, input logic [15:0] seq);
        if (k < 512)
            return {32'(4 * k), 32'hA500_0000 + 32'(k), 4'hF, 1'b0,
                    (k % 8 == 7) ? 3'b111 : 3'b010, k % 8 == 0};
        if (k == 512) return {32'h1000, 16'h0, seq, 4'hF, 1'b1, 3'b000, 1'b1};
        return {32'h1020, 32'h1, 4'h1, 1'b1, 3'b000, 1'b1};
    endfunction

    task automatic check_sector(input int tb, input int sb, input logic [15:0] seq);
        chk($sformatf("s%0d_trans_count", seq), trans_q.size() - tb, 514);
        for (int k = 0; k < 514; k++)
            chk($sformatf("s%0d_trans%0d", seq, k),
                (tb + k < trans_q.size()) ? trans_q[tb + k] : trans_t'(0), exp_trans(k, seq));
        chk($sformatf("s%0d_stream_count", seq), strm_q.size() - sb, 512);
        for (int k = 0; k < 512; k++)
            chk($sformatf("s%0d_word%0d", seq, k),
                (sb + k < strm_q.size()) ? strm_q[sb + k] : 33'(0),
                {k == 511, 32'hA500_0000 + 32'(k)});
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int lim, output int n);
        n = 0;
        while (cnt !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("sector%0d_done", v), cnt, v);
    endtask

    initial begin
        int tb, sb, n;
        repeat (3) @(negedge clk);
        chk("reset_bus", {adr, dat_o, sel, we, cti, bte, cyc, stb}, 0);
        chk("reset_misc", {m_data, m_valid, m_last, busy, err_o, cnt}, 0);
        rst_n = 1;
        @(negedge clk);
        wint = 1;
        tb = trans_q.size();
        repeat (30) @(negedge clk);
        chk("disabled_no_bus", trans_q.size() - tb, 0);
        chk("disabled_idle", busy, 0);

        ready_mode = 1;
        enable = 1;
        tb = trans_q.size();
        sb = strm_q.size();
        wait_cnt(1, 2000, n);
        chk("sector1_cycles_le_660", n <= 660, 1);
        check_sector(tb, sb, 1);
        repeat (6) @(negedge clk);
        chk("rearm_no_restart", trans_q.size() - tb, 514);
        chk("rearm_busy", busy, 1);
        wint = 0;
        @(negedge clk);
        chk("rearm_to_idle", busy, 0);

        ready_mode = 2;
        wint = 1;
        tb = trans_q.size();
        sb = strm_q.size();
        wait_cnt(2, 20000, n);
        check_sector(tb, sb, 2);
        chk("max_occupancy_le_16", max_occ <= 16, 1);
        chk("burst_start_free", start_viol, 0);
        wint = 0;
        repeat (2) @(negedge clk);

        ready_mode = 1;
        wint = 1;
        tb = trans_q.size();
        sb = strm_q.size();
        n = 0;
        while (strm_q.size() - sb < 200 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_word200", strm_q.size() - sb >= 200, 1);
        enable = 0;
        wait_cnt(3, 2000, n);
        check_sector(tb, sb, 3);
        wint = 0;
        repeat (2) @(negedge clk);
        wint = 1;
        tb = trans_q.size();
        repeat (30) @(negedge clk);
        chk("disabled_after_sector", trans_q.size() - tb, 0);
        chk("disabled_after_busy", busy, 0);

        enable = 1;
        n = 0;
        while (!(trans_q.size() - tb >= 20 && cyc) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_burst_reached", cyc, 1);
        #2 rst_n = 0;
        err_arm = 1;
        #1;
        chk("async_reset_bus", {adr, dat_o, sel, we, cti, bte, cyc, stb}, 0);
        chk("async_reset_misc", {m_data, m_valid, m_last, busy, err_o, cnt}, 0);
        tb = trans_q.size();
        sb = strm_q.size();
        @(negedge clk);
        rst_n = 1;
        n = 0;
        while (err_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("err_set", err_o, 1);
        chk("err_cyc_dropped", cyc, 0);
        chk("err_busy", busy, 1);
        repeat (100) @(negedge clk);
        chk("err_beats_acked", trans_q.size() - tb, 83);
        chk("restart_addr0", (trans_q.size() > tb) ? trans_q[tb].adr : 32'hFFFF_FFFF, 0);
        chk("err_words_streamed", strm_q.size() - sb, 83);
        chk("err_last_word", (strm_q.size() > sb) ? strm_q[strm_q.size() - 1] : 33'(0), {1'b0, 32'hA500_0052});
        chk("err_no_more_bus", cyc, 0);
        chk("err_sticky", {err_o, busy}, 2'b11);
        chk("err_fifo_empty", m_valid, 0);
        chk("err_cnt_zero", cnt, 0);
        chk("protocol", proto_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fauxfs_wfile_drain.md
# fauxfs_wfile_drain

Wishbone master on the fauxfs CPU-side bus that drains each 2 KB write-file sector deposited by the SD host. When the write-file pending interrupt rises, it burst-reads the 512-word buffer into a 32-bit valid/ready stream for the downstream storage engine. It then writes the sector sequence number to ack word 0, clears the pending flag, and re-arms once the interrupt has dropped.

## Interface
- BASE_ADR, 32'h0000_0000: base of the fauxfs CPU window. Write-file data at +0x0000..+0x07FC, ack word 0 at +0x1000, status/clear at +0x1020 (bit0 = write-file pending, write 1 to clear).
- BURST_LEN, 8: beats per read burst; power of 2, divides 512.
- FIFO_DEPTH, 16: stream FIFO entries; power of 2, ≥ 2×BURST_LEN.

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_rst_n_i  in  1  reset; one clock, reset asynchronous, active-low
- enable_i  in  1  allow new sectors to start
- wfile_dat_int_i  in  1  write-file pending (level, already synchronous to wb_clk_i)
- wbm_adr_o  out  32  byte address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_we_o  out  1  write enable
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type, always 2'b00
- wbm_cyc_o / wbm_stb_o  out  1  bus cycle / strobe
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- m_data_o  out  32  stream data (FIFO head)
- m_valid_o  out  1  stream valid
- m_last_o  out  1  marks word 511 of a sector
- m_ready_i  in  1  stream ready
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  sticky bus error
- sector_cnt_o  out  16  completed sectors, wraps 0xFFFF→0

## Operation
States: IDLE, RD, GAP, FLUSH, ACKWR, CLRWR, REARM, ERR.
- IDLE: on enable_i & wfile_dat_int_i, go to GAP with word index 0.
- GAP: cyc/stb low. Go to RD when FIFO free entries ≥ BURST_LEN.
- RD: incrementing burst at BASE_ADR + 4·index.
  - wbm_cti_o = 3'b010 on all beats except the last, which uses 3'b111.
  - we=0, sel=4'hF.
  - Each ack pushes wbm_dat_i into the FIFO, tagged last when index = 511, and increments index and address by 4.
  - After the final beat's ack, cyc/stb drop: to GAP if index < 512, else to FLUSH.
- FLUSH: wait until the FIFO is empty, i.e. the consumer holds the whole sector.
- ACKWR: classic write (cti=000, we=1, sel=4'hF) to +0x1000 with data {16'h0, sector_cnt_o+1}. On ack, go to CLRWR.
- CLRWR: classic write to +0x1020 with sel=4'h1 and data 32'h1. On ack, sector_cnt_o increments; go to REARM.
- REARM: wait for wfile_dat_int_i low, which takes several cycles while the clear crosses domains. Then go to IDLE.
- Stream side:
  - m_valid_o = FIFO not empty.
  - A word is popped when m_valid_o & m_ready_i.
  - Push and pop in the same cycle keep the count unchanged.
- enable_i low mid-sector does not abort; it only blocks the next start from IDLE.
- wbm_err_i in any bus state: drop cyc/stb that cycle, set err_o, enter ERR.
  - ERR is terminal until reset.
  - The FIFO keeps draining to the stream, but no new bus cycles are issued.

## Timing
- Reset (wb_rst_n_i low, asynchronous): state IDLE; all outputs 0 (cti=000, bte=00); FIFO empty; index 0; sector_cnt_o 0; err_o 0.
- cyc/stb are registered outputs and must be low for ≥1 cycle between any two bus cycles, because the slave detects a new cycle on the cyc&stb rising edge.
- Burst throughput: the slave acks every cycle, so a full burst holds cyc for BURST_LEN ack cycles plus ≥1 idle cycle. With m_ready_i held high, a sector takes about 512 + 2·(512/BURST_LEN) cycles.
- Classic writes: the slave acks one cycle after stb; stb drops the cycle after ack.
- The FIFO never overflows: GAP guarantees BURST_LEN free entries before a burst starts.
- m_data_o/m_last_o are valid combinationally from the FIFO head whenever m_valid_o is high.
- Index wrap: the counter is 10 bits wide; it reaches 512 only at the transition to FLUSH and is cleared on entry to GAP from IDLE.
- Interrupt already high when entering IDLE from REARM is impossible; REARM waits for low. A new rise then starts the next sector on the following cycle.

## Test plan
- Model slave preloaded with data word i = 0xA500_0000+i; raise int with m_ready_i=1. Required:
  - 64 bursts of 8, address sequence 0x0..0x7FC, correct cti pattern;
  - stream of 512 words in order, m_last_o only on 0xA500_01FF;
  - then write 0x0000_0001 to 0x1000, write 0x1 sel=0001 to 0x1020;
  - sector_cnt_o=1.
- m_ready_i toggled randomly at 30%: FIFO count ≤ 16, no lost or duplicated words, no burst starts with <8 free entries.
- Keep int high for 6 cycles after the clear write: no second sector starts until int drops; then a second sector gives ack data 0x0000_0002.
- Assert wbm_err_i on beat 3 of burst 10: cyc drops the same cycle; err_o=1 and busy_o stays 1; the 83 buffered words still stream out; no further bus cycles.
- Assert wb_rst_n_i mid-burst: all outputs 0 immediately (asynchronous); after release, a new int restarts from address 0x0.
- enable_i=0 with int high: no bus activity. Drop enable_i during word 200: the sector completes, then the block idles.
